key_press_classifier: RTL

//  Consumes the debounced, active-high key level and classifies each gesture
//  as short press, long press or double press, with single-cycle event pulses.

---
 rtl/key_pkg.sv | 32 +++
 rtl/key_edge_detect.sv | 20 ++
 rtl/key_press_classifier.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key press classifier.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } keyState_t;

  localparam int unsigned DEF_LONG_TICKS   = 16;
  localparam int unsigned DEF_DOUBLE_TICKS = 8;
  localparam int unsigned DEF_REPEAT_TICKS = 4;
  localparam int unsigned DEF_CNT_W        = 8;

  localparam int unsigned MIN_LONG_TICKS   = 2;
  localparam int unsigned MIN_DOUBLE_TICKS = 1;
  localparam int unsigned MIN_REPEAT_TICKS = 1;

  function automatic int unsigned atLeast(input int unsigned v, input int unsigned lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Previous-sample register for the debounced key, with rise/fall strobes.
module key_edge_detect (
  input  logic iClock,
  input  logic iReset,
  input  logic iKey,
  output logic oRise,
  output logic oFall
);

  logic kPrev;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) kPrev <= 1'b0;
    else        kPrev <= iKey;
  end

  assign oRise = iKey & ~kPrev;
  assign oFall = ~iKey & kPrev;

endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced key gestures into press/short/long/double pulses.
// Optional auto-repeat while long-held is enabled by defining KEY_AUTOREPEAT_EN.
module key_press_classifier
  import key_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned DOUBLE_TICKS = DEF_DOUBLE_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic iClock,
  input  logic iReset,
  input  logic iKey,
  output logic oPress,
  output logic oShort,
  output logic oLong,
  output logic oDouble,
  output logic oRepeat,
  output logic oHeld
);

  localparam int unsigned LongEff   = atLeast(LONG_TICKS, MIN_LONG_TICKS);
  localparam int unsigned DoubleEff = atLeast(DOUBLE_TICKS, MIN_DOUBLE_TICKS);
  localparam int unsigned RepeatEff = atLeast(REPEAT_TICKS, MIN_REPEAT_TICKS);
  localparam int unsigned NeedW     = $clog2(maxOf3(LongEff, DoubleEff, RepeatEff) + 1);
  localparam int unsigned CntWEff   = (CNT_W > NeedW) ? CNT_W : NeedW;

  // The entering edge is itself the first sample of a run, so thresholds sit two
  // below the tick count: one for that edge, one because the counter starts at 0.
  localparam logic [CntWEff-1:0] LongLast   = CntWEff'(LongEff - 2);
  localparam logic [CntWEff-1:0] DoubleLast = CntWEff'((DoubleEff >= 2) ? DoubleEff - 2 : 0);

  keyState_t          state;
  logic [CntWEff-1:0] cnt;
  logic [CntWEff-1:0] cntInc;
  logic               rise;
  logic               fall;

  key_edge_detect uEdge (
    .iClock (iClock),
    .iReset (iReset),
    .iKey   (iKey),
    .oRise  (rise),
    .oFall  (fall)
  );

  assign cntInc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CntWEff-1:0] RepeatLast = CntWEff'(RepeatEff - 1);
  logic repeatQ;
  assign oRepeat = repeatQ;
`else
  assign oRepeat = 1'b0;
`endif

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      cnt     <= '0;
      oPress  <= 1'b0;
      oShort  <= 1'b0;
      oLong   <= 1'b0;
      oDouble <= 1'b0;
      oHeld   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      repeatQ <= 1'b0;
`endif
    end else begin
      oPress  <= rise;
      oShort  <= 1'b0;
      oLong   <= 1'b0;
      oDouble <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      repeatQ <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
            cnt   <= '0;
            oHeld <= 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= WAIT_SECOND;
            cnt   <= '0;
            oHeld <= 1'b0;
          end else if (cnt >= LongLast) begin
            state <= LONG_HELD;
            cnt   <= '0;
            oLong <= 1'b1;
          end else begin
            cnt <= cntInc;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
            oHeld <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
          end else if (cnt >= RepeatLast) begin
            cnt     <= '0;
            repeatQ <= 1'b1;
`endif
          end else begin
            cnt <= cntInc;
          end
        end
        WAIT_SECOND: begin
          if (rise) begin
            state <= SECOND_PRESSED;
            cnt   <= '0;
            oHeld <= 1'b1;
          end else if (cnt >= DoubleLast) begin
            state  <= IDLE;
            cnt    <= '0;
            oShort <= 1'b1;
          end else begin
            cnt <= cntInc;
          end
        end
        SECOND_PRESSED: begin
          if (fall) begin
            state   <= IDLE;
            cnt     <= '0;
            oDouble <= 1'b1;
            oHeld   <= 1'b0;
          end else if (cnt >= LongLast) begin
            state <= LONG_HELD;
            cnt   <= '0;
            oLong <= 1'b1;
          end else begin
            cnt <= cntInc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          oHeld <= 1'b0;
        end
      endcase
    end
  end

endmodule
